// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: instruction-memory port, decode handoff and control/status.
// The sequencer owns the master side.
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned INSTR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic               halt;
  logic               resume;
  logic [ADDR_W-1:0]  pc;
  logic               halted;
  logic               fetch_err;
  logic               misalign_err;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, pc, halted, fetch_err, misalign_err,
    input  imem_ack, imem_rdata, instr_ready, branch_taken, branch_target, halt, resume
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc, halted, fetch_err, misalign_err,
    output imem_ack, imem_rdata, instr_ready, branch_taken, branch_target, halt, resume
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: fetches from instruction memory, hands each instruction
// to decode, and applies redirects, halts and fetch-timeout / misalignment flags.
module fetch_sequencer #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4,
  parameter int unsigned       TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_sequencer_if.master  bus
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]         state_q, state_nxt;
  logic [ADDR_W-1:0]  pc_q, pc_nxt;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_nxt;
  logic [INSTR_W-1:0] instr_q, instr_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic               ferr_q, ferr_nxt;
  logic               merr_q, merr_nxt;
  logic               req_q, valid_q, halted_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_nxt;
  end

  // Next state and next datapath values
  always_comb begin
    state_nxt    = state_q;
    pc_nxt       = pc_q;
    instr_nxt    = instr_q;
    instr_pc_nxt = instr_pc_q;
    cnt_nxt      = '0;
    ferr_nxt     = ferr_q;
    merr_nxt     = merr_q;
    case (state_q)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        // An ack arriving on the final allowed cycle still wins over the timeout
        if (bus.imem_ack) begin
          instr_nxt    = bus.imem_rdata;
          instr_pc_nxt = pc_q;
          pc_nxt       = ADDR_W'(pc_q + ADDR_W'(PC_STEP));
          state_nxt    = S_ISSUE;
        end else if (CNT_W'(cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT)) begin
          ferr_nxt  = 1'b1;
          state_nxt = S_HALT;
        end else begin
          cnt_nxt = CNT_W'(cnt_q + CNT_W'(1));
        end
      end
      S_ISSUE: begin
        if (bus.instr_ready) begin
          if (bus.branch_taken) begin
            pc_nxt = {bus.branch_target[ADDR_W-1:2], 2'b00};
            if (|bus.branch_target[1:0]) merr_nxt = 1'b1;
          end
          state_nxt = bus.halt ? S_HALT : S_FETCH;
        end
      end
      S_HALT: if (bus.resume) state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      cnt_q      <= '0;
      ferr_q     <= 1'b0;
      merr_q     <= 1'b0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      pc_q       <= pc_nxt;
      instr_q    <= instr_nxt;
      instr_pc_q <= instr_pc_nxt;
      cnt_q      <= cnt_nxt;
      ferr_q     <= ferr_nxt;
      merr_q     <= merr_nxt;
      req_q      <= (state_nxt == S_FETCH);
      valid_q    <= (state_nxt == S_ISSUE);
      halted_q   <= (state_nxt == S_HALT);
    end
  end

  assign bus.imem_req     = req_q;
  assign bus.imem_addr    = pc_q;
  assign bus.instr_valid  = valid_q;
  assign bus.instr        = instr_q;
  assign bus.instr_pc     = instr_pc_q;
  assign bus.pc           = pc_q;
  assign bus.halted       = halted_q;
  assign bus.fetch_err    = ferr_q;
  assign bus.misalign_err = merr_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios then randomized fetch/issue traffic,
// checked against a transaction-level model of PC, instruction and sticky flags.
module tb_fetch_sequencer;
  localparam int unsigned TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_sequencer_if bus ();
  fetch_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

  int n_total = 0;
  int n_pass  = 0;

  logic [15:0] m_pc;
  logic [31:0] m_instr;
  logic [15:0] m_ipc;
  logic        m_ferr, m_merr;

  task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s.%s: observed %h expected %h", tag, what, obs, exp);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, "req_seen", 32'(bus.imem_req), 32'd1);
  endtask

  task automatic fetch_one(input int lat, input logic [31:0] data, input string tag);
    wait_req(tag);
    check(tag, "addr", 32'(bus.imem_addr), 32'(m_pc));
    check(tag, "valid_lo", 32'(bus.instr_valid), 32'd0);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check(tag, "wait_req", 32'(bus.imem_req), 32'd1);
      check(tag, "wait_addr", 32'(bus.imem_addr), 32'(m_pc));
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = data;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
    m_instr = data;
    m_ipc   = m_pc;
    m_pc    = m_pc + 16'd4;
    check(tag, "valid", 32'(bus.instr_valid), 32'd1);
    check(tag, "instr", bus.instr, m_instr);
    check(tag, "instr_pc", 32'(bus.instr_pc), 32'(m_ipc));
    check(tag, "req_lo", 32'(bus.imem_req), 32'd0);
    check(tag, "pc_inc", 32'(bus.pc), 32'(m_pc));
    check(tag, "ferr", 32'(bus.fetch_err), 32'(m_ferr));
  endtask

  task automatic issue_one(input int stall, input logic br, input logic [15:0] tgt, input logic hlt, input string tag);
    for (int i = 0; i < stall; i++) begin
      bus.instr_ready   = 1'b0;
      bus.branch_taken  = 1'($urandom);
      bus.halt          = 1'($urandom);
      bus.branch_target = 16'($urandom);
      bus.imem_ack      = 1'($urandom);
      @(negedge clk);
      check(tag, "stall_valid", 32'(bus.instr_valid), 32'd1);
      check(tag, "stall_instr", bus.instr, m_instr);
      check(tag, "stall_ipc", 32'(bus.instr_pc), 32'(m_ipc));
      check(tag, "stall_pc", 32'(bus.pc), 32'(m_pc));
      check(tag, "stall_req", 32'(bus.imem_req), 32'd0);
      check(tag, "stall_halted", 32'(bus.halted), 32'd0);
    end
    bus.instr_ready   = 1'b1;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    bus.halt          = hlt;
    bus.imem_ack      = 1'b0;
    @(negedge clk);
    bus.instr_ready  = 1'b0;
    bus.branch_taken = 1'b0;
    bus.halt         = 1'b0;
    if (br) begin
      m_pc = tgt & 16'hFFFC;
      if (tgt[1:0] != 2'b00) m_merr = 1'b1;
    end
    check(tag, "acc_pc", 32'(bus.pc), 32'(m_pc));
    check(tag, "acc_merr", 32'(bus.misalign_err), 32'(m_merr));
    check(tag, "acc_valid", 32'(bus.instr_valid), 32'd0);
    if (hlt) begin
      check(tag, "acc_halted", 32'(bus.halted), 32'd1);
      check(tag, "acc_req_lo", 32'(bus.imem_req), 32'd0);
    end else begin
      check(tag, "acc_req", 32'(bus.imem_req), 32'd1);
      check(tag, "acc_addr", 32'(bus.imem_addr), 32'(m_pc));
    end
  endtask

  task automatic halt_idle_resume(input int idle, input string tag);
    for (int i = 0; i < idle; i++) begin
      bus.imem_ack   = 1'($urandom);
      bus.imem_rdata = $urandom;
      @(negedge clk);
      check(tag, "halt_halted", 32'(bus.halted), 32'd1);
      check(tag, "halt_pc", 32'(bus.pc), 32'(m_pc));
      check(tag, "halt_req", 32'(bus.imem_req), 32'd0);
      check(tag, "halt_valid", 32'(bus.instr_valid), 32'd0);
    end
    bus.imem_ack = 1'b0;
    bus.resume   = 1'b1;
    @(negedge clk);
    bus.resume = 1'b0;
    check(tag, "res_halted", 32'(bus.halted), 32'd0);
    check(tag, "res_req", 32'(bus.imem_req), 32'd1);
    check(tag, "res_addr", 32'(bus.imem_addr), 32'(m_pc));
    check(tag, "res_ferr", 32'(bus.fetch_err), 32'(m_ferr));
    check(tag, "res_merr", 32'(bus.misalign_err), 32'(m_merr));
  endtask

  task automatic timeout_case(input string tag);
    wait_req(tag);
    check(tag, "to_addr", 32'(bus.imem_addr), 32'(m_pc));
    for (int i = 1; i < int'(TIMEOUT); i++) begin
      @(negedge clk);
      check(tag, "to_req", 32'(bus.imem_req), 32'd1);
      check(tag, "to_halted", 32'(bus.halted), 32'd0);
      check(tag, "to_ferr_pre", 32'(bus.fetch_err), 32'(m_ferr));
    end
    @(negedge clk);
    m_ferr = 1'b1;
    check(tag, "to_ferr", 32'(bus.fetch_err), 32'd1);
    check(tag, "to_halted_hi", 32'(bus.halted), 32'd1);
    check(tag, "to_req_lo", 32'(bus.imem_req), 32'd0);
    check(tag, "to_pc", 32'(bus.pc), 32'(m_pc));
  endtask

  task automatic reset_checks(input string tag);
    check(tag, "pc", 32'(bus.pc), 32'h0000);
    check(tag, "req", 32'(bus.imem_req), 32'd0);
    check(tag, "valid", 32'(bus.instr_valid), 32'd0);
    check(tag, "halted", 32'(bus.halted), 32'd0);
    check(tag, "instr", bus.instr, 32'd0);
    check(tag, "instr_pc", 32'(bus.instr_pc), 32'd0);
    check(tag, "ferr", 32'(bus.fetch_err), 32'd0);
    check(tag, "merr", 32'(bus.misalign_err), 32'd0);
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.imem_ack      = 1'b0;
    bus.imem_rdata    = '0;
    bus.instr_ready   = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.halt          = 1'b0;
    bus.resume        = 1'b0;
    m_pc = 16'h0000; m_ferr = 1'b0; m_merr = 1'b0; m_instr = '0; m_ipc = '0;

    // Reset state
    repeat (2) @(negedge clk);
    reset_checks("reset");
    rst_n = 1'b1;

    // Sequential fetches, 1-cycle ack latency: 0x0000, 0x0004, 0x0008
    for (int k = 0; k < 3; k++) begin
      fetch_one(1, 32'hA000_0000 + 32'(k), "seq");
      issue_one(0, 1'b0, 16'h0, 1'b0, "seq");
    end

    // Decode back-pressure for 3 cycles
    fetch_one(0, 32'hDEAD_BEEF, "stall");
    issue_one(3, 1'b0, 16'h0, 1'b0, "stall");

    // Aligned and misaligned redirects
    fetch_one(0, 32'h1111_2222, "br");
    issue_one(0, 1'b1, 16'h0040, 1'b0, "br_al");
    fetch_one(0, 32'h3333_4444, "br");
    issue_one(0, 1'b1, 16'h0042, 1'b0, "br_mis");

    // Ack on the last allowed cycle beats the timeout
    fetch_one(int'(TIMEOUT) - 1, 32'h5555_6666, "ack_edge");
    issue_one(0, 1'b0, 16'h0, 1'b0, "ack_edge");

    // Fetch timeout, stale acks in HALT, resume at same pc
    timeout_case("timeout");
    halt_idle_resume(3, "timeout");
    fetch_one(1, 32'h7777_8888, "post_to");
    issue_one(0, 1'b1, 16'hFFFC, 1'b0, "to_wrap");

    // PC wrap from 0xFFFC, then halt together with branch
    fetch_one(0, 32'h9999_AAAA, "wrap");
    check("wrap", "pc_zero", 32'(bus.pc), 32'h0000);
    issue_one(1, 1'b1, 16'h0100, 1'b1, "halt_br");
    check("halt_br", "pc_0100", 32'(bus.pc), 32'h0100);
    halt_idle_resume(2, "halt_br");

    // Reset in FETCH coinciding with ack; late ack during IDLE is ignored
    wait_req("rst_mid");
    rst_n          = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    reset_checks("rst_mid");
    rst_n = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    m_pc = 16'h0000; m_ferr = 1'b0; m_merr = 1'b0;
    check("rst_mid", "late_req", 32'(bus.imem_req), 32'd1);
    check("rst_mid", "late_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_mid", "late_addr", 32'(bus.imem_addr), 32'h0000);
    check("rst_mid", "late_instr", bus.instr, 32'd0);

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      int          lat, stall;
      logic        br, hlt;
      logic [15:0] tgt;
      lat   = int'($urandom_range(0, 4));
      stall = int'($urandom_range(0, 3));
      br    = ($urandom % 3) == 0;
      hlt   = ($urandom % 6) == 0;
      tgt   = 16'($urandom);
      fetch_one(lat, $urandom, "rand");
      issue_one(stall, br, tgt, hlt, "rand");
      if (hlt) halt_idle_resume(int'($urandom_range(0, 3)), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
